// File: rtl/tb_uart.sv
// tb_uart: 8N1 host-side UART transceiver with a fixed clocks-per-bit divider.
// The receiver is built only when TB_UART_RX_EN is defined; otherwise rx_* outputs are tied to 0.
module tb_uart #(
  parameter int CLKS_PER_BIT = 347
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       ser_rx,
  output logic       ser_tx,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_clear_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_WAIT_CLR} tx_state_t;
  tx_state_t r_tx_st, w_tx_st_nxt;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0] r_tx_idx, w_tx_idx_nxt;
  logic [7:0] r_tx_shift, w_tx_shift_nxt;
  logic r_ser_tx, r_tx_busy, r_tx_clr;
  logic w_ser_tx_nxt, w_tx_busy_nxt, w_tx_clr_nxt, w_tx_bit_end;

  assign w_tx_bit_end = (r_tx_cnt == LAST);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_tx_st    <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_ser_tx   <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_tx_clr   <= 1'b0;
    end else begin
      r_tx_st    <= w_tx_st_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_idx   <= w_tx_idx_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_ser_tx   <= w_ser_tx_nxt;
      r_tx_busy  <= w_tx_busy_nxt;
      r_tx_clr   <= w_tx_clr_nxt;
    end
  end

  // Outputs are registered from the next state so ser_tx never glitches.
  always_comb begin
    w_tx_st_nxt    = r_tx_st;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_idx_nxt   = r_tx_idx;
    w_tx_shift_nxt = r_tx_shift;
    case (r_tx_st)
      TX_IDLE: if (tx_start) begin
        w_tx_st_nxt    = TX_START;
        w_tx_shift_nxt = tx_data;
        w_tx_cnt_nxt   = '0;
        w_tx_idx_nxt   = '0;
      end
      TX_START: begin
        w_tx_cnt_nxt = w_tx_bit_end ? '0 : r_tx_cnt + 1'b1;
        w_tx_st_nxt  = w_tx_bit_end ? TX_DATA : TX_START;
      end
      TX_DATA: begin
        w_tx_cnt_nxt = w_tx_bit_end ? '0 : r_tx_cnt + 1'b1;
        w_tx_idx_nxt = w_tx_bit_end ? r_tx_idx + 1'b1 : r_tx_idx;
        w_tx_st_nxt  = (w_tx_bit_end && r_tx_idx == 3'd7) ? TX_STOP : TX_DATA;
      end
      TX_STOP: begin
        w_tx_cnt_nxt = w_tx_bit_end ? '0 : r_tx_cnt + 1'b1;
        w_tx_st_nxt  = !w_tx_bit_end ? TX_STOP : tx_start ? TX_WAIT_CLR : TX_IDLE;
      end
      TX_WAIT_CLR: w_tx_st_nxt = tx_start ? TX_WAIT_CLR : TX_IDLE;
      default: w_tx_st_nxt = TX_IDLE;
    endcase
    w_ser_tx_nxt  = (w_tx_st_nxt == TX_START) ? 1'b0 :
                    (w_tx_st_nxt == TX_DATA)  ? w_tx_shift_nxt[w_tx_idx_nxt] : 1'b1;
    w_tx_busy_nxt = (w_tx_st_nxt == TX_START) || (w_tx_st_nxt == TX_DATA) || (w_tx_st_nxt == TX_STOP);
    w_tx_clr_nxt  = (w_tx_st_nxt == TX_WAIT_CLR);
  end

  assign ser_tx       = r_ser_tx;
  assign tx_busy      = r_tx_busy;
  assign tx_clear_req = r_tx_clr;

`ifdef TB_UART_RX_EN
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t r_rx_st, w_rx_st_nxt;
  logic r_rx_meta, r_rx_sync;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0] r_rx_idx, w_rx_idx_nxt;
  logic [7:0] r_rx_shift, w_rx_shift_nxt, r_rx_data, w_rx_data_nxt;
  logic r_rx_hold, w_rx_hold_nxt, r_rx_valid, w_rx_valid_nxt, r_rx_err, w_rx_err_nxt;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_st    <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_hold  <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      r_rx_meta  <= ser_rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_st    <= w_rx_st_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_idx   <= w_rx_idx_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_hold  <= w_rx_hold_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_rx_err   <= w_rx_err_nxt;
    end
  end

  // r_rx_hold keeps STOP parked after a low stop bit until the line returns high.
  always_comb begin
    w_rx_st_nxt    = r_rx_st;
    w_rx_cnt_nxt   = r_rx_cnt + 1'b1;
    w_rx_idx_nxt   = r_rx_idx;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_data_nxt  = r_rx_data;
    w_rx_hold_nxt  = r_rx_hold;
    w_rx_valid_nxt = 1'b0;
    w_rx_err_nxt   = 1'b0;
    case (r_rx_st)
      RX_IDLE: begin
        w_rx_cnt_nxt = '0;
        w_rx_st_nxt  = r_rx_sync ? RX_IDLE : RX_START;
      end
      RX_START: if (r_rx_cnt == HALF) begin
        w_rx_cnt_nxt = '0;
        w_rx_idx_nxt = '0;
        w_rx_st_nxt  = r_rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (r_rx_cnt == LAST) begin
        w_rx_cnt_nxt   = '0;
        w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
        w_rx_idx_nxt   = r_rx_idx + 1'b1;
        w_rx_st_nxt    = (r_rx_idx == 3'd7) ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (r_rx_hold) begin
        w_rx_cnt_nxt  = '0;
        w_rx_hold_nxt = !r_rx_sync;
        w_rx_st_nxt   = r_rx_sync ? RX_IDLE : RX_STOP;
      end else if (r_rx_cnt == LAST) begin
        w_rx_cnt_nxt   = '0;
        w_rx_valid_nxt = r_rx_sync;
        w_rx_err_nxt   = !r_rx_sync;
        w_rx_data_nxt  = r_rx_sync ? r_rx_shift : r_rx_data;
        w_rx_hold_nxt  = !r_rx_sync;
        w_rx_st_nxt    = r_rx_sync ? RX_IDLE : RX_STOP;
      end
      default: w_rx_st_nxt = RX_IDLE;
    endcase
  end

  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign rx_frame_err = r_rx_err;
`else
  logic w_unused_rx;
  assign w_unused_rx  = ser_rx;
  assign rx_data      = '0;
  assign rx_valid     = 1'b0;
  assign rx_frame_err = 1'b0;
`endif
endmodule

// File: tb/tb_tb_uart.sv
// tb_tb_uart: directed bench for tb_uart at CLKS_PER_BIT=16 with TX/RX byte scoreboards.
// RX expectations follow whether TB_UART_RX_EN is defined for the build.
module tb_tb_uart;
  localparam int CPB = 16;
`ifdef TB_UART_RX_EN
  localparam int RX_EN = 1;
`else
  localparam int RX_EN = 0;
`endif
  logic clk = 1'b0, resetb = 1'b0, tx_start = 1'b0, rx_drv = 1'b1, loop = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic ser_rx, ser_tx, tx_busy, tx_clear_req, rx_valid, rx_frame_err;
  logic [7:0] rx_data;
  logic [7:0] sb_tx[$];
  logic [7:0] sb_rx[$];
  logic [9:0] fr;
  int checks = 0, errors = 0, n_valid = 0, n_err = 0, v0 = 0, bad = 0;

  assign ser_rx = loop ? ser_tx : rx_drv;
  always #5 clk = ~clk;

  tb_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clk), .resetb(resetb), .ser_rx(ser_rx), .ser_tx(ser_tx),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_clear_req(tx_clear_req),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: drop tx_start mid-frame; 1: hold to end then drop; 2: hold and leave high
  task automatic tx_frame(input logic [7:0] b, input int mode, output logic [9:0] got);
    logic [9:0] efr;
    int n, nbad;
    efr = {1'b1, b, 1'b0};
    got = '0;
    n = 0;
    nbad = 0;
    sb_tx.push_back(b);
    tx_start = 1'b1;
    tx_data = b;
    @(negedge clk);
    chk("tx_start_latency", 32'(tx_busy && !ser_tx), 1);
    while (tx_busy && n < 400) begin
      if (ser_tx !== efr[0]) nbad++;
      if (n % CPB == CPB / 2) got = {ser_tx, got[9:1]};
      if (n % CPB == CPB - 1) efr = {1'b1, efr[9:1]};
      tx_data = ~b;
      if (mode == 0 && n == 20) tx_start = 1'b0;
      n++;
      @(negedge clk);
    end
    chk("tx_busy_len", n, 10 * CPB);
    chk("tx_bit_timing", nbad, 0);
    chk("tx_framing", 32'({got[9], got[0]}), 'b10);
    chk("tx_sb_data", 32'(got[8:1]), 32'(sb_tx.pop_front()));
    chk("tx_clr_at_end", 32'(tx_clear_req), mode != 0 ? 1 : 0);
    if (mode == 1) begin
      tx_start = 1'b0;
      @(negedge clk);
      chk("tx_clr_fall", 32'(tx_clear_req), 0);
    end
  endtask

  task automatic rx_drive(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[0];
      f = f >> 1;
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      chk("rx_exclusive", 32'(rx_frame_err), 0);
      if (sb_rx.size() == 0) chk("rx_sb_unexpected", 32'(rx_data), 'h100);
      else chk("rx_sb_data", 32'(rx_data), 32'(sb_rx.pop_front()));
    end
    if (rx_frame_err) n_err++;
  end

  initial begin
    repeat (6) begin
      @(negedge clk);
      rx_drv = ~rx_drv;
      chk("rst_hold", 32'({ser_tx, tx_busy, tx_clear_req, rx_data, rx_valid, rx_frame_err}), 'h1000);
    end
    rx_drv = 1'b1;
    @(negedge clk);
    resetb = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_release", 32'({ser_tx, tx_busy, tx_clear_req, rx_data, rx_valid, rx_frame_err}), 'h1000);
    tx_frame(8'h00, 1, fr);
    tx_frame(8'h01, 1, fr);
    tx_frame(8'h02, 1, fr);
    chk("tx_0x02_bits", 32'(fr), 'b1000000100);
    tx_frame(8'hC3, 0, fr);
    tx_frame(8'h81, 2, fr);
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (ser_tx !== 1'b1 || tx_busy !== 1'b0 || tx_clear_req !== 1'b1) bad++;
    end
    chk("hs_hold_no_refire", bad, 0);
    tx_start = 1'b0;
    @(negedge clk);
    chk("hs_clr_fall", 32'(tx_clear_req), 0);
    tx_frame(8'h5A, 1, fr);
    loop = 1'b1;
    v0 = n_valid;
    if (RX_EN != 0) sb_rx.push_back(8'hA5);
    tx_frame(8'hA5, 1, fr);
    repeat (40) @(negedge clk);
    loop = 1'b0;
    chk("lb_valid_cnt", n_valid - v0, RX_EN);
    chk("lb_no_err", n_err, 0);
    chk("lb_data", 32'(rx_data), RX_EN != 0 ? 'hA5 : 0);
    chk("lb_sb_empty", sb_rx.size(), 0);
    v0 = n_valid;
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_no_valid", n_valid - v0, 0);
    chk("glitch_no_err", n_err, 0);
    rx_drive(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    chk("ferr_cnt", n_err, RX_EN);
    chk("ferr_no_valid", n_valid - v0, 0);
    chk("ferr_data_kept", 32'(rx_data), RX_EN != 0 ? 'hA5 : 0);
    if (RX_EN != 0) sb_rx.push_back(8'h3C);
    rx_drive(8'h3C, 1'b1);
    repeat (40) @(negedge clk);
    chk("rx_good_valid", n_valid - v0, RX_EN);
    chk("rx_good_data", 32'(rx_data), RX_EN != 0 ? 'h3C : 0);
    chk("rx_good_no_err", n_err, RX_EN);
    tx_start = 1'b1;
    tx_data = 8'h96;
    repeat (1 + 4 * CPB + 3) @(negedge clk);
    chk("mid_busy_before_rst", 32'(tx_busy), 1);
    #2;
    resetb = 1'b0;
    tx_start = 1'b0;
    #1;
    chk("rst_async", 32'({ser_tx, tx_busy, tx_clear_req}), 'b100);
    repeat (3) @(negedge clk);
    chk("rst_mid_hold", 32'({ser_tx, tx_busy, tx_clear_req, rx_valid, rx_frame_err}), 'b10000);
    resetb = 1'b1;
    repeat (5) @(negedge clk);
    tx_frame(8'h96, 1, fr);
    chk("tx_sb_empty", sb_tx.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
